// File: rtl/wm8960_i2c_pkg.sv
// Shared types and constants for the WM8960 control-port responder.
// FSM encoding, default device address and bit-counter widths live here.
package wm8960_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEVADDR,
    DEVACK,
    BYTE1,
    ACK1,
    BYTE2,
    ACK2,
    IGNORE
  } state_t;

  localparam logic [6:0] WM8960_DEV_ADDR = 7'h1A;
  localparam int         WM8960_NUM_REGS = 56;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 4;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
  localparam bit_cnt_t BITS_PER_BYTE = bit_cnt_t'(BYTE_W);

  function automatic logic is_ack_state(input state_t s);
    return (s == DEVACK) || (s == ACK1) || (s == ACK2);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// I2C line conditioning: 2-flop synchronizer, FILT_LEN-sample glitch filter
// and edge detection, producing SCL edge and START/STOP pulses. FILT_LEN >= 2.
module i2c_line_cond #(
  parameter int FILT_LEN = 3
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam int SCL_CH = 0;
  localparam int SDA_CH = 1;

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw = {sda, scl};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic                sync1_reg;
      logic                sync2_reg;
      logic [FILT_LEN-1:0] hist_reg;
      logic                filt_reg;
      logic                filt_next;
      logic                rise_reg;
      logic                fall_reg;

      // The filtered level only moves once FILT_LEN consecutive samples agree.
      always_comb begin
        filt_next = filt_reg;
        if (&hist_reg)
          filt_next = 1'b1;
        else if (~|hist_reg)
          filt_next = 1'b0;
      end

      // Idle bus is high, so everything resets to 1 to avoid a false edge.
      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          hist_reg  <= '1;
          filt_reg  <= 1'b1;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          hist_reg  <= {hist_reg[FILT_LEN-2:0], sync2_reg};
          filt_reg  <= filt_next;
          rise_reg  <= filt_next & ~filt_reg;
          fall_reg  <= ~filt_next & filt_reg;
        end
      end

      assign lvl[gi]  = filt_reg;
      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;
    end
  endgenerate

  assign sda_lvl  = lvl[SDA_CH];
  assign scl_rise = rise[SCL_CH];
  assign scl_fall = fall[SCL_CH];
  assign start    = fall[SDA_CH] & lvl[SCL_CH];
  assign stop     = rise[SDA_CH] & lvl[SCL_CH];

endmodule

// File: rtl/wm8960_i2c_responder.sv
// Write-only I2C target emulating the WM8960 control port, keeping a
// readable shadow copy of every register the bus master programs.
module wm8960_i2c_responder
  import wm8960_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = WM8960_DEV_ADDR,
  parameter int         NUM_REGS = WM8960_NUM_REGS,
  parameter int         FILT_LEN = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic        Reg_Wr_En,
  output logic [6:0]  Reg_Addr,
  output logic [8:0]  Reg_Data,
  output logic        Addr_Err,
  output logic        Busy,
  input  logic [6:0]  Rd_Addr,
  output logic [8:0]  Rd_Data,
  output logic [15:0] Frame_Cnt
);

  // NUM_REGS is limited to 128 by the 7-bit register index.
  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  state_t            state_reg, state_next;
  bit_cnt_t          bit_cnt_reg;
  logic [BYTE_W-1:0] shift_reg;
  logic [6:0]        reg_idx_reg;
  logic              d8_reg;
  logic [6:0]        reg_addr_reg;
  logic [8:0]        reg_data_reg;
  logic [8:0]        rd_data_reg;
  logic              reg_wr_en_reg;
  logic              addr_err_reg;
  logic [15:0]       frame_cnt_reg;
  logic [8:0]        shadow_reg [NUM_REGS];

  logic sda_lvl, scl_rise, scl_fall, start, stop;
  logic sda_oe, busy;
  logic bus_evt, byte_done, sampling, commit, wr_in_range, rd_in_range;

  i2c_line_cond #(
    .FILT_LEN(FILT_LEN)
  ) u_line_cond (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .scl      (i2c_sclk),
    .sda      (i2c_sdat),
    .sda_lvl  (sda_lvl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign bus_evt     = start | stop;
  assign byte_done   = (bit_cnt_reg == BITS_PER_BYTE);
  assign sampling    = (state_reg == DEVADDR) || (state_reg == BYTE1) || (state_reg == BYTE2);
  assign commit      = !bus_evt && scl_fall && byte_done && (state_reg == BYTE2);
  assign wr_in_range = ({1'b0, reg_idx_reg} < NUM_REGS_W);
  assign rd_in_range = ({1'b0, Rd_Addr} < NUM_REGS_W);

  always_ff @(posedge Clk) begin
    if (!Rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // START/STOP win over any SCL edge seen in the same cycle.
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = DEVADDR;
    end else if (stop) begin
      state_next = IDLE;
    end else if (scl_fall) begin
      case (state_reg)
        DEVADDR: if (byte_done) state_next = (shift_reg == {DEV_ADDR, 1'b0}) ? DEVACK : IGNORE;
        DEVACK:  state_next = BYTE1;
        BYTE1:   if (byte_done) state_next = ACK1;
        ACK1:    state_next = BYTE2;
        BYTE2:   if (byte_done) state_next = ACK2;
        ACK2:    state_next = BYTE1;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    sda_oe = 1'b0;
    busy   = 1'b1;
    case (state_reg)
      IDLE:               busy   = 1'b0;
      DEVACK, ACK1, ACK2: sda_oe = 1'b1;
      default:            ;
    endcase
  end

  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      reg_idx_reg <= '0;
      d8_reg      <= 1'b0;
    end else begin
      if (bus_evt) begin
        bit_cnt_reg <= '0;
      end else if (scl_rise && sampling && !byte_done) begin
        shift_reg   <= {shift_reg[BYTE_W-2:0], sda_lvl};
        bit_cnt_reg <= bit_cnt_reg + bit_cnt_t'(1);
      end else if (scl_fall && is_ack_state(state_reg)) begin
        bit_cnt_reg <= '0;
      end
      // First data byte carries {reg[6:0], data[8]}.
      if (!bus_evt && scl_fall && byte_done && (state_reg == BYTE1))
        {reg_idx_reg, d8_reg} <= shift_reg;
    end
  end

  // Shadow file and write reporting; a same-cycle read returns the old value.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      reg_wr_en_reg <= 1'b0;
      addr_err_reg  <= 1'b0;
      reg_addr_reg  <= '0;
      reg_data_reg  <= '0;
      frame_cnt_reg <= '0;
      rd_data_reg   <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        shadow_reg[i] <= '0;
    end else begin
      reg_wr_en_reg <= commit && wr_in_range;
      addr_err_reg  <= commit && !wr_in_range;
      if (commit && wr_in_range) begin
        reg_addr_reg                        <= reg_idx_reg;
        reg_data_reg                        <= {d8_reg, shift_reg};
        shadow_reg[reg_idx_reg[IDX_W-1:0]]  <= {d8_reg, shift_reg};
        if (frame_cnt_reg != 16'hFFFF)
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      rd_data_reg <= rd_in_range ? shadow_reg[Rd_Addr[IDX_W-1:0]] : '0;
    end
  end

  assign Reg_Wr_En = reg_wr_en_reg;
  assign Reg_Addr  = reg_addr_reg;
  assign Reg_Data  = reg_data_reg;
  assign Addr_Err  = addr_err_reg;
  assign Busy      = busy;
  assign Rd_Data   = rd_data_reg;
  assign Frame_Cnt = frame_cnt_reg;

endmodule

// File: tb/tb_wm8960_i2c_responder.sv
// Bench for wm8960_i2c_responder: bit-banged I2C master, table of frames
// with hand-computed results, plus reset, restart and glitch sequences.
module tb_wm8960_i2c_responder;

  localparam int Q = 10;  // quarter SCL period in Clk cycles

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        scl;
  logic        m_sda_low;
  wire         i2c_sdat;
  logic        Reg_Wr_En;
  logic [6:0]  Reg_Addr;
  logic [8:0]  Reg_Data;
  logic        Addr_Err;
  logic        Busy;
  logic [6:0]  Rd_Addr;
  logic [8:0]  Rd_Data;
  logic [15:0] Frame_Cnt;

  always #5 Clk = ~Clk;

  assign i2c_sdat = m_sda_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  wm8960_i2c_responder dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .i2c_sclk  (scl),
    .i2c_sdat  (i2c_sdat),
    .Reg_Wr_En (Reg_Wr_En),
    .Reg_Addr  (Reg_Addr),
    .Reg_Data  (Reg_Data),
    .Addr_Err  (Addr_Err),
    .Busy      (Busy),
    .Rd_Addr   (Rd_Addr),
    .Rd_Data   (Rd_Data),
    .Frame_Cnt (Frame_Cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Event monitor, sampled on the falling edge.
  int         wr_seen  = 0;
  int         err_seen = 0;
  int         drv_seen = 0;
  logic [8:0] rd_at_wr    = '0;
  logic [8:0] rd_after_wr = '0;
  logic       was_wr      = 1'b0;

  always @(negedge Clk) begin
    if (Reg_Wr_En) wr_seen++;
    if (Addr_Err)  err_seen++;
    if (i2c_sdat === 1'b0 && !m_sda_low) drv_seen++;
    if (was_wr)    rd_after_wr = Rd_Data;
    if (Reg_Wr_En) rd_at_wr = Rd_Data;
    was_wr = Reg_Wr_En;
  end

  task automatic q_wait();
    repeat (Q) @(posedge Clk);
    #1;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      m_sda_low = 1'b0; q_wait();
      scl = 1'b1;       q_wait();
    end
    m_sda_low = 1'b1; q_wait(); q_wait();
    scl = 1'b0;       q_wait();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda_low = !b[i]; q_wait();
      scl = 1'b1;        q_wait(); q_wait();
      scl = 1'b0;        q_wait();
    end
  endtask

  task automatic ack_bit(output logic acked);
    m_sda_low = 1'b0; q_wait();
    scl = 1'b1;       q_wait();
    acked = (i2c_sdat === 1'b0);
    q_wait();
    scl = 1'b0;       q_wait();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; q_wait();
    scl = 1'b1;       q_wait();
    m_sda_low = 1'b0; q_wait(); q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8);
    ack_bit(acked);
  endtask

  task automatic read_shadow(input logic [6:0] idx, output logic [8:0] val);
    Rd_Addr = idx;
    @(posedge Clk); #1;
    val = Rd_Data;
  endtask

  typedef struct {
    int              nbytes;
    logic [4:0][7:0] bytes;
    logic [4:0]      exp_ack;
    int              exp_wr;
    int              exp_err;
    logic [6:0]      chk_idx;
    logic [8:0]      chk_val;
    logic [6:0]      exp_laddr;
    logic [8:0]      exp_ldata;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3, b4,
                              input logic [4:0] acks, input int wr, input int err,
                              input logic [6:0] cidx, input logic [8:0] cval,
                              input logic [6:0] laddr, input logic [8:0] ldata);
    vec_t v;
    v.nbytes = n;
    v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2; v.bytes[3] = b3; v.bytes[4] = b4;
    v.exp_ack = acks; v.exp_wr = wr; v.exp_err = err;
    v.chk_idx = cidx; v.chk_val = cval; v.exp_laddr = laddr; v.exp_ldata = ldata;
    return v;
  endfunction

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int         w0, e0, d0, exp_frames, found;
    logic       a;
    logic [4:0] acks;
    logic [8:0] val;

    //            n  b0     b1     b2     b3     b4     acks      wr err idx    val      laddr  ldata
    vecs[0] = mk(3, 8'h34, 8'h0E, 8'h0A, 8'h00, 8'h00, 5'b00111, 1, 0, 7'h07, 9'h00A, 7'h07, 9'h00A);
    vecs[1] = mk(3, 8'h36, 8'h0E, 8'h0A, 8'h00, 8'h00, 5'b00000, 0, 0, 7'h07, 9'h00A, 7'h07, 9'h00A);
    vecs[2] = mk(3, 8'h35, 8'h0E, 8'h0A, 8'h00, 8'h00, 5'b00000, 0, 0, 7'h07, 9'h00A, 7'h07, 9'h00A);
    vecs[3] = mk(5, 8'h34, 8'h0F, 8'hFF, 8'h10, 8'h01, 5'b11111, 2, 0, 7'h07, 9'h1FF, 7'h08, 9'h001);
    vecs[4] = mk(3, 8'h34, 8'h7E, 8'h55, 8'h00, 8'h00, 5'b00111, 0, 1, 7'h3F, 9'h000, 7'h00, 9'h000);
    vecs[5] = mk(3, 8'h34, 8'h6F, 8'h81, 8'h00, 8'h00, 5'b00111, 1, 0, 7'h37, 9'h181, 7'h37, 9'h181);
    vecs[6] = mk(3, 8'h34, 8'h70, 8'h00, 8'h00, 8'h00, 5'b00111, 0, 1, 7'h38, 9'h000, 7'h00, 9'h000);

    Rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0; Rd_Addr = '0;
    repeat (5) @(posedge Clk);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_wr_en", Reg_Wr_En, 0);
    check("rst_frame_cnt", Frame_Cnt, 0);
    check("rst_reg_addr", Reg_Addr, 0);
    check("rst_sda_released", i2c_sdat, 1);
    Rst_n = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    exp_frames = 0;

    for (int v = 0; v < NV; v++) begin
      w0 = wr_seen; e0 = err_seen; d0 = drv_seen;
      acks = '0;
      bus_start();
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        send_byte(vecs[v].bytes[k], a);
        acks[k] = a;
      end
      bus_stop();
      repeat (5) @(posedge Clk);
      #1;
      exp_frames += vecs[v].exp_wr;
      check($sformatf("v%0d_acks", v), acks, vecs[v].exp_ack);
      check($sformatf("v%0d_wr_pulses", v), wr_seen - w0, vecs[v].exp_wr);
      check($sformatf("v%0d_err_pulses", v), err_seen - e0, vecs[v].exp_err);
      check($sformatf("v%0d_sda_driven", v), (drv_seen - d0) != 0, vecs[v].exp_ack != 0);
      check($sformatf("v%0d_frame_cnt", v), Frame_Cnt, exp_frames);
      check($sformatf("v%0d_busy_after_stop", v), Busy, 0);
      if (vecs[v].exp_wr > 0) begin
        check($sformatf("v%0d_reg_addr", v), Reg_Addr, vecs[v].exp_laddr);
        check($sformatf("v%0d_reg_data", v), Reg_Data, vecs[v].exp_ldata);
      end
      read_shadow(vecs[v].chk_idx, val);
      check($sformatf("v%0d_shadow", v), val, vecs[v].chk_val);
      $display("vec %0d: %0d bytes, acks=%b wr=%0d err=%0d shadow[0x%0h]=0x%0h frames=%0d",
               v, vecs[v].nbytes, acks, wr_seen - w0, err_seen - e0, vecs[v].chk_idx, val, Frame_Cnt);
    end

    // Pair cut short by STOP, then by a repeated START inside BYTE2.
    w0 = wr_seen;
    bus_start();
    send_byte(8'h34, a); send_byte(8'h0E, a);
    bus_stop();
    repeat (5) @(posedge Clk);
    #1;
    check("partial_stop_busy", Busy, 0);
    check("partial_stop_no_wr", wr_seen - w0, 0);
    bus_start();
    send_byte(8'h34, a); send_byte(8'h0E, a);
    send_bits(8'hA5, 4);
    bus_start();
    check("restart_busy", Busy, 1);
    check("restart_no_wr", wr_seen - w0, 0);
    send_byte(8'h34, a); send_byte(8'h10, a); send_byte(8'h22, a);
    bus_stop();
    repeat (5) @(posedge Clk);
    #1;
    exp_frames += 1;
    check("restart_one_wr", wr_seen - w0, 1);
    read_shadow(7'h07, val);
    check("restart_shadow7_kept", val, 9'h1FF);
    read_shadow(7'h08, val);
    check("restart_shadow8", val, 9'h022);
    $display("restart: wr=%0d frames=%0d", wr_seen - w0, Frame_Cnt);

    // Read of the index being written: old value first, new one a cycle later.
    Rd_Addr = 7'h07;
    bus_start();
    send_byte(8'h34, a); send_byte(8'h0E, a); send_byte(8'hAB, a);
    bus_stop();
    repeat (5) @(posedge Clk);
    #1;
    exp_frames += 1;
    check("rw_same_cycle_old", rd_at_wr, 9'h1FF);
    check("rw_next_cycle_new", rd_after_wr, 9'h0AB);
    check("rw_frame_cnt", Frame_Cnt, exp_frames);
    $display("read-during-write: at=0x%0h after=0x%0h", rd_at_wr, rd_after_wr);

    // One-cycle SDA glitches while SCL is high.
    m_sda_low = 1'b1;
    @(posedge Clk); #1;
    m_sda_low = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    check("glitch_no_start", Busy, 0);
    m_sda_low = 1'b1; q_wait(); q_wait();
    check("real_start", Busy, 1);
    m_sda_low = 1'b0;
    @(posedge Clk); #1;
    m_sda_low = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    check("glitch_no_stop", Busy, 1);
    m_sda_low = 1'b0; q_wait(); q_wait();
    check("real_stop", Busy, 0);
    $display("glitch: busy=%0b", Busy);

    // Reset while the responder holds the device-address ACK.
    bus_start();
    send_bits(8'h34, 8);
    m_sda_low = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge Clk); #1;
      if (i2c_sdat === 1'b0) found = 1;
    end
    check("devack_driven", found, 1);
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    check("rst_midframe_sda_released", i2c_sdat, 1);
    check("rst_midframe_busy", Busy, 0);
    repeat (4) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    scl = 1'b1;
    q_wait();
    check("rst_midframe_frame_cnt", Frame_Cnt, 0);
    read_shadow(7'h07, val);
    check("rst_shadow7", val, 0);
    read_shadow(7'h37, val);
    check("rst_shadow55", val, 0);
    w0 = wr_seen;
    acks = '0;
    bus_start();
    for (int k = 0; k < 3; k++) begin
      send_byte(vecs[0].bytes[k], a);
      acks[k] = a;
    end
    bus_stop();
    repeat (5) @(posedge Clk);
    #1;
    check("post_rst_acks", acks, 5'b00111);
    check("post_rst_wr", wr_seen - w0, 1);
    check("post_rst_frame_cnt", Frame_Cnt, 1);
    read_shadow(7'h07, val);
    check("post_rst_shadow7", val, 9'h00A);
    $display("post-reset frame: acks=%b shadow[7]=0x%0h frames=%0d", acks, val, Frame_Cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wm8960_i2c_responder.md
Name: wm8960_i2c_responder

Overview:
- Synthesizable I2C target that emulates the WM8960 control interface: 7-bit device address, write-only, two data bytes per register write ({reg[6:0], data[8]}, data[7:0]).
- Sits on the same i2c_sclk/i2c_sdat bus as the codec-init master. Serves as an on-chip loopback target for bring-up, and as a shadow of every register the master has programmed.
- Holds a readable shadow register file so other logic can check the codec configuration without reading back from the codec.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address that the block acknowledges.
- NUM_REGS, 56, number of shadow registers (indices 0..NUM_REGS-1).
- FILT_LEN, 3, number of consecutive equal synchronized samples needed to accept an SCL/SDA level change (glitch filter).

Ports:
- Clk  input  1  system clock; must be at least 16x the SCL frequency.
- Rst_n  input  1  synchronous, active-low reset.
- i2c_sclk  input  1  bus clock, sampled only, never driven.
- i2c_sdat  inout  1  open-drain data: driven 0 only during ACK, otherwise high-Z.
- Reg_Wr_En  output  1  one-cycle pulse when a complete register write is accepted.
- Reg_Addr  output  7  register index of the last accepted write.
- Reg_Data  output  9  data of the last accepted write.
- Addr_Err  output  1  one-cycle pulse when a write targets an index >= NUM_REGS.
- Busy  output  1  high from START to STOP.
- Rd_Addr  input  7  shadow read index.
- Rd_Data  output  9  shadow[Rd_Addr], registered with 1-cycle latency; 0 if Rd_Addr >= NUM_REGS.
- Frame_Cnt  output  16  count of accepted writes, saturating at 16'hFFFF.

Behaviour:
Reset:
- Rst_n low on a rising Clk edge clears all outputs, all shadow registers and Frame_Cnt to 0, releases i2c_sdat, and puts the FSM in IDLE.
- Reset asserted mid-frame aborts the frame. SDA is released in the same cycle the reset is sampled.

Line conditioning:
- 2-flop synchronizer, then the FILT_LEN glitch filter, then edge detect.
- START: filtered SDA falls while SCL is high.
- STOP: filtered SDA rises while SCL is high.
- Data bits are sampled on SCL rising edges, MSB first.

FSM states: IDLE, DEVADDR, DEVACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
- IDLE: on START, go to DEVADDR and assert Busy.
- DEVADDR: shift in 8 bits.
  - If the 8th bit is taken, addr==DEV_ADDR and R/W==0: on the following SCL fall, drive SDA low and go to DEVACK.
  - Otherwise: leave SDA released (NACK) and go to IGNORE.
- DEVACK, ACK1, ACK2: hold SDA low through the 9th SCL high. On the 9th SCL fall, release SDA and advance:
  - DEVACK goes to BYTE1.
  - ACK1 goes to BYTE2.
  - ACK2 goes to BYTE1, so multiple register pairs per transaction are allowed.
- BYTE1: after 8 bits, latch reg[6:0] and d8, then ACK.
- BYTE2: after 8 bits, ACK.
  - On the SCL fall that starts ACK2 (call it cycle T after filtering), Reg_Wr_En pulses at T+1.
  - At T+1, Reg_Addr/Reg_Data update, the shadow is written (only if reg < NUM_REGS), and Frame_Cnt increments.
  - If reg >= NUM_REGS: still ACK, pulse Addr_Err instead of Reg_Wr_En, no shadow write, no count.
- IGNORE: SDA released until STOP or START.
- STOP in any state: go to IDLE, release SDA, deassert Busy. A partial pair is discarded.
- Repeated START in any state: go to DEVADDR, clear the bit counter, discard any partial pair.

Boundary rules:
- START/STOP detection takes priority over a data-bit sample in the same cycle.
- A shadow write and a Rd_Addr read of the same index in the same cycle return the old value; the new value appears on the next cycle.
- Frame_Cnt saturates and does not wrap.

Decomposition:
- Package wm8960_i2c_pkg holds:
  - FSM state encoding
  - default DEV_ADDR (7'h1A)
  - WM8960_NUM_REGS (56)
  - byte/bit-count widths
- Sub-module i2c_line_cond: synchronizer, glitch filter, and scl_rise/scl_fall/start/stop pulse outputs. Reusable by the master side.

Test Plan:
1. Master sends START, 0x34, 0x0E, 0x0A, STOP -> three ACKs; Reg_Wr_En pulses once with Reg_Addr=0x07, Reg_Data=0x00A; shadow[7]=0x00A; Frame_Cnt=1; Busy low after STOP.
2. Master sends START, 0x36, 0x0E, 0x0A, STOP, then repeats it with 0x35 as the address byte -> NACK on the address byte both times; SDA never driven; no Reg_Wr_En; Frame_Cnt unchanged.
3. Master sends START, 0x34, 0x0F, 0xFF, 0x10, 0x01, STOP -> two pulses; shadow[7]=0x1FF, shadow[8]=0x001; Frame_Cnt +2.
4. Master sends START, 0x34, 0x0E, STOP, then a repeated START mid-BYTE2 of a new frame -> no write; FSM back in IDLE/DEVADDR respectively; shadow unchanged.
5. Master sends START, 0x34, 0x7E, 0x55, STOP (reg 0x3F >= 56) -> all ACKed; Addr_Err pulses; no Reg_Wr_En; Rd_Addr=0x3F gives Rd_Data=0.
6. Rst_n pulled low during the DEVACK low phase -> SDA released the same cycle; all shadows 0; the next full frame from case 1 succeeds. A 1-Clk SDA glitch with SCL high is not detected as START/STOP (FILT_LEN=3).
